mac_rx: RTL and testbench

MAC_RX -- requirements
Module: mac_rx

---
 rtl/mac_rx.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mac_rx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx.sv
`default_nettype none
// ============================================================================
// Module   : mac_rx
// Purpose  : GMII receiver that accepts Ethernet/IPv4/UDP frames addressed to
//            this node and streams the UDP payload out, one byte per beat.
// Revision : 1.0 - initial release
// ============================================================================
module mac_rx #(
    parameter string CHECK_CRC = "TRUE"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [31:0] rx_src_ip,
    output logic [15:0] rx_src_port,
    output logic [15:0] rx_len,
    output logic        frame_ok,
    output logic        frame_err
);

    localparam bit          c_CRC_EN      = (CHECK_CRC != "FALSE");
    localparam logic [31:0] c_CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] c_CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_ETH_HDR  = 3'd2,
        S_IP_HDR   = 3'd3,
        S_UDP_HDR  = 3'd4,
        S_PAYLOAD  = 3'd5,
        S_TAIL     = 3'd6,
        S_DROP     = 3'd7
    } state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (c_CRC_POLY & {32{c[0] ^ data[i]}});
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        ucast_q, ucast_d;
    logic        bcast_q, bcast_d;
    logic        acc_q, acc_d;
    logic [31:0] sip_q, sip_d;
    logic [15:0] sport_q, sport_d;
    logic [7:0]  lenhi_q, lenhi_d;
    logic [15:0] plen_q, plen_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] len_q, len_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    // Byte of local_mac / local_ip that lines up with the header byte on rxd.
    logic [47:0] w_mac_sh;
    logic [31:0] w_ip_sh;
    logic [7:0]  w_mac_byte;
    logic [7:0]  w_ip_byte;
    logic        w_ucast_now;
    logic        w_bcast_now;
    logic [15:0] w_udp_len;
    logic [31:0] w_crc_next;
    logic        w_last_beat;
    logic        w_crc_good;

    assign w_mac_sh    = local_mac << {cnt_q[2:0], 3'b000};
    assign w_ip_sh     = local_ip << {cnt_q[1:0], 3'b000};
    assign w_mac_byte  = w_mac_sh[47:40];
    assign w_ip_byte   = w_ip_sh[31:24];
    assign w_ucast_now = ucast_q && (rxd == w_mac_byte);
    assign w_bcast_now = bcast_q && (rxd == 8'hFF);
    assign w_udp_len   = {lenhi_q, rxd};
    assign w_crc_next  = crc_step(crc_q, rxd);
    assign w_last_beat = (cnt_q == plen_q - 16'd1);
    assign w_crc_good  = !c_CRC_EN || (crc_q == c_CRC_RESIDUE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        ucast_d    = ucast_q;
        bcast_d    = bcast_q;
        acc_d      = acc_q;
        sip_d      = sip_q;
        sport_d    = sport_q;
        lenhi_d    = lenhi_q;
        plen_d     = plen_q;
        tdata_d    = tdata_q;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        src_ip_d   = src_ip_q;
        src_port_d = src_port_q;
        len_d      = len_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                acc_d = 1'b0;
                if (rx_dv) begin
                    state_d = (rxd == 8'h55) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rx_er) begin
                    state_d = S_DROP;
                end else if (rxd == 8'hD5) begin
                    state_d = S_ETH_HDR;
                    cnt_d   = '0;
                    crc_d   = '1;
                    ucast_d = 1'b1;
                    bcast_d = 1'b1;
                end else if (rxd != 8'h55) begin
                    state_d = S_DROP;
                end
            end
            S_ETH_HDR: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rx_er) begin
                    state_d = S_DROP;
                end else begin
                    crc_d = w_crc_next;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q < 16'd6) begin
                        ucast_d = w_ucast_now;
                        bcast_d = w_bcast_now;
                        if (cnt_q == 16'd5 && !w_ucast_now && !w_bcast_now) state_d = S_DROP;
                    end
                    if (cnt_q == 16'd12 && rxd != 8'h08) state_d = S_DROP;
                    if (cnt_q == 16'd13) begin
                        cnt_d   = '0;
                        state_d = (rxd == 8'h00) ? S_IP_HDR : S_DROP;
                    end
                end
            end
            S_IP_HDR: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rx_er) begin
                    state_d = S_DROP;
                end else begin
                    crc_d = w_crc_next;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == 16'd0 && rxd != 8'h45) state_d = S_DROP;
                    if (cnt_q == 16'd9 && rxd != 8'h11) state_d = S_DROP;
                    if (cnt_q >= 16'd12 && cnt_q <= 16'd15) sip_d = {sip_q[23:0], rxd};
                    if (cnt_q >= 16'd16 && rxd != w_ip_byte) state_d = S_DROP;
                    if (cnt_q == 16'd19) begin
                        cnt_d = '0;
                        if (rxd == w_ip_byte) state_d = S_UDP_HDR;
                    end
                end
            end
            S_UDP_HDR: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rx_er) begin
                    state_d = S_DROP;
                end else begin
                    crc_d = w_crc_next;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q <= 16'd1) sport_d = {sport_q[7:0], rxd};
                    if (cnt_q == 16'd2 && rxd != local_port[15:8]) state_d = S_DROP;
                    if (cnt_q == 16'd3 && rxd != local_port[7:0]) state_d = S_DROP;
                    if (cnt_q == 16'd4) lenhi_d = rxd;
                    if (cnt_q == 16'd5) begin
                        plen_d = w_udp_len - 16'd8;
                        if (w_udp_len < 16'd8) state_d = S_DROP;
                    end
                    // Last header byte: every filter has passed, the frame is ours.
                    if (cnt_q == 16'd7) begin
                        acc_d      = 1'b1;
                        src_ip_d   = sip_q;
                        src_port_d = sport_q;
                        len_d      = plen_q;
                        cnt_d      = '0;
                        state_d    = (plen_q == 16'd0) ? S_TAIL : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!rx_dv) begin
                    err_d   = 1'b1;
                    acc_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (rx_er) begin
                    state_d = S_DROP;
                end else begin
                    crc_d    = w_crc_next;
                    cnt_d    = cnt_q + 16'd1;
                    tdata_d  = rxd;
                    tvalid_d = 1'b1;
                    tuser_d  = (cnt_q == 16'd0);
                    tlast_d  = w_last_beat;
                    if (w_last_beat) state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (!rx_dv) begin
                    ok_d    = w_crc_good;
                    err_d   = !w_crc_good;
                    acc_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (rx_er) begin
                    state_d = S_DROP;
                end else begin
                    crc_d = w_crc_next;
                end
            end
            S_DROP: begin
                if (!rx_dv) begin
                    err_d   = acc_q;
                    acc_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            crc_q      <= '1;
            ucast_q    <= 1'b0;
            bcast_q    <= 1'b0;
            acc_q      <= 1'b0;
            sip_q      <= '0;
            sport_q    <= '0;
            lenhi_q    <= '0;
            plen_q     <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            len_q      <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            ucast_q    <= ucast_d;
            bcast_q    <= bcast_d;
            acc_q      <= acc_d;
            sip_q      <= sip_d;
            sport_q    <= sport_d;
            lenhi_q    <= lenhi_d;
            plen_q     <= plen_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            src_ip_q   <= src_ip_d;
            src_port_q <= src_port_d;
            len_q      <= len_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign rx_src_ip     = src_ip_q;
    assign rx_src_port   = src_port_q;
    assign rx_len        = len_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_rx
// Purpose  : Directed and random frames for mac_rx, checked against a
//            frame-level parser model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [15:0] local_port;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [31:0] rx_src_ip;
    logic [15:0] rx_src_port, rx_len;
    logic        frame_ok, frame_err;

    mac_rx dut (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .local_mac(local_mac), .local_ip(local_ip), .local_port(local_port),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port), .rx_len(rx_len),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        int         c;
    } beat_t;

    beat_t mon_q[$];
    beat_t mon_b;
    int    ok_cnt = 0, err_cnt = 0, both_cnt = 0, pulse_cyc = 0;

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            mon_b.d = m_axis_tdata;
            mon_b.u = m_axis_tuser;
            mon_b.l = m_axis_tlast;
            mon_b.c = cyc;
            mon_q.push_back(mon_b);
        end
        if (frame_ok) begin ok_cnt++; pulse_cyc = cyc; end
        if (frame_err) begin err_cnt++; pulse_cyc = cyc; end
        if (frame_ok && frame_err) both_cnt++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] frm[$];
    logic [7:0] body[$];
    int         drv_cyc[$];
    int         low_cyc;

    // Model results; exp_len/sip/sport persist like the DUT's last-accepted registers.
    logic [7:0]  exp_beats[$];
    int          exp_res, exp_plen, exp_pay0;
    logic [15:0] exp_len = 0, exp_sport = 0;
    logic [31:0] exp_sip = 0;

    function automatic logic [31:0] crc8(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
            else c = c >> 1;
        end
        return c;
    endfunction

    task automatic put(input logic [31:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) body.push_back(v[8*i +: 8]);
    endtask

    task automatic build(input int npre, input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [7:0] ip0, input logic [7:0] proto, input logic [31:0] dip,
                         input logic [15:0] dport, input logic [15:0] ulen, input int npay,
                         input int flip, input bit pattern);
        logic [31:0] c, fcs;
        body.delete();
        frm.delete();
        put(dmac[47:16], 4); put({16'h0, dmac[15:0]}, 2);
        put($urandom, 4); put($urandom, 2);
        put({16'h0, etype}, 2);
        put({24'h0, ip0}, 1); put(0, 1); put({16'h0, ulen + 16'd20}, 2);
        put($urandom, 4); put(32'd64, 1); put({24'h0, proto}, 1); put(0, 2);
        put($urandom, 4); put(dip, 4);
        put($urandom, 2); put({16'h0, dport}, 2); put({16'h0, ulen}, 2); put(0, 2);
        for (int i = 0; i < npay; i++) body.push_back(pattern ? 8'(i + 1) : 8'($urandom));
        while (body.size() < 60) body.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc8(c, body[i]);
        fcs = ~c;
        if (flip >= 0) fcs = fcs ^ (32'h1 << flip);
        repeat (npre) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        foreach (body[i]) frm.push_back(body[i]);
        put(fcs, 0);
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endtask

    // Parses the bytes actually delivered (first n, cut short at an rx_er byte e).
    task automatic model(input int n, input int e);
        int lim, h, plen, nb;
        logic [47:0] dm;
        logic [31:0] dip, c;
        logic [15:0] ul;
        exp_beats.delete();
        exp_res = 0; exp_plen = 0; exp_pay0 = 0;
        lim = (e >= 1 && e < n) ? e : n;
        h = 0;
        while (h < lim && frm[h] == 8'h55) h++;
        if (h == 0 || h >= lim || frm[h] != 8'hD5) return;
        h++;
        if (lim < h + 42) return;
        dm = 0;
        for (int i = 0; i < 6; i++) dm = {dm[39:0], frm[h+i]};
        dip = 0;
        for (int i = 0; i < 4; i++) dip = {dip[23:0], frm[h+30+i]};
        ul = {frm[h+38], frm[h+39]};
        if (dm != local_mac && dm != 48'hFFFF_FFFF_FFFF) return;
        if ({frm[h+12], frm[h+13]} != 16'h0800) return;
        if (frm[h+14] != 8'h45 || frm[h+23] != 8'h11) return;
        if (dip != local_ip || {frm[h+36], frm[h+37]} != local_port) return;
        if (ul < 16'd8) return;
        plen      = int'(ul) - 8;
        exp_plen  = plen;
        exp_len   = plen[15:0];
        exp_sip   = {frm[h+26], frm[h+27], frm[h+28], frm[h+29]};
        exp_sport = {frm[h+34], frm[h+35]};
        exp_pay0  = h + 42;
        nb = lim - (h + 42);
        if (nb > plen) nb = plen;
        for (int i = 0; i < nb; i++) exp_beats.push_back(frm[h+42+i]);
        if (lim < n || nb < plen) begin
            exp_res = 2;
        end else begin
            c = 32'hFFFFFFFF;
            for (int i = h; i < n; i++) c = crc8(c, frm[i]);
            exp_res = (c == 32'hDEBB20E3) ? 1 : 2;
        end
    endtask

    task automatic send(input int n, input int e, input int rst_at);
        mon_q.delete();
        drv_cyc.delete();
        ok_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rxd   = frm[i];
            rx_er = (i == e);
            reset = (i == rst_at);
            drv_cyc.push_back(cyc);
        end
        @(negedge clk);
        rx_dv = 1'b0; rx_er = 1'b0; reset = 1'b0; rxd = 8'h00;
        low_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        int bad;
        bad = 0;
        check({tag, ".beats"}, 64'(mon_q.size()), 64'(exp_beats.size()));
        for (int i = 0; i < mon_q.size() && i < exp_beats.size(); i++) begin
            if (mon_q[i].d !== exp_beats[i]) bad++;
            if (mon_q[i].u !== (i == 0)) bad++;
            if (mon_q[i].l !== (i == exp_plen - 1)) bad++;
        end
        check({tag, ".content"}, 64'(bad), 0);
        check({tag, ".ok"}, 64'(ok_cnt), 64'(exp_res == 1));
        check({tag, ".err"}, 64'(err_cnt), 64'(exp_res == 2));
        check({tag, ".rx_len"}, 64'(rx_len), 64'(exp_len));
        check({tag, ".src_ip"}, 64'(rx_src_ip), 64'(exp_sip));
        check({tag, ".src_port"}, 64'(rx_src_port), 64'(exp_sport));
        if (exp_beats.size() > 0 && mon_q.size() > 0)
            check({tag, ".beat_lat"}, 64'(mon_q[0].c), 64'(drv_cyc[exp_pay0] + 1));
        if (exp_res != 0 && ok_cnt + err_cnt > 0)
            check({tag, ".pulse_cyc"}, 64'(pulse_cyc), 64'(low_cyc + 1));
    endtask

    task automatic run(input string tag, input int n, input int e);
        model(n, e);
        send(n, e, -1);
        verify(tag);
    endtask

    initial begin
        int n, e, kind, npre, ulen, npay, flip;
        logic [47:0] dmac;
        logic [15:0] etype, dport;
        logic [7:0]  ip0, proto;
        logic [31:0] dip;

        local_mac  = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
        local_ip   = $urandom;
        local_port = 16'($urandom_range(1, 16'hFFFE));

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.tdata", 64'(m_axis_tdata), 0);
        check("rst.tvalid", 64'(m_axis_tvalid), 0);
        check("rst.tlast", 64'(m_axis_tlast), 0);
        check("rst.tuser", 64'(m_axis_tuser), 0);
        check("rst.src_ip", 64'(rx_src_ip), 0);
        check("rst.src_port", 64'(rx_src_port), 0);
        check("rst.rx_len", 64'(rx_len), 0);
        check("rst.ok", 64'(frame_ok), 0);
        check("rst.err", 64'(frame_err), 0);

        build(7, local_mac, 16'h0800, 8'h45, 8'h11, local_ip, local_port, 16'd12, 4, -1, 1'b1);
        run("good4", frm.size(), -1);
        check("good4.len4", 64'(rx_len), 4);
        check("good4.nbeats4", 64'(mon_q.size()), 4);

        build(7, local_mac, 16'h0800, 8'h45, 8'h11, local_ip, local_port, 16'd12, 4, 13, 1'b1);
        run("badfcs", frm.size(), -1);
        check("badfcs.err1", 64'(err_cnt), 1);

        build(7, local_mac, 16'h0800, 8'h45, 8'h11, local_ip, local_port + 16'd1, 16'd12, 4, -1, 1'b1);
        run("port+1", frm.size(), -1);
        build(7, local_mac, 16'h0806, 8'h45, 8'h11, local_ip, local_port, 16'd12, 4, -1, 1'b1);
        run("arp", frm.size(), -1);
        check("arp.len_kept", 64'(rx_len), 4);

        build(3, 48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'h11, local_ip, local_port, 16'd8, 0, -1, 1'b0);
        run("bcast0", frm.size(), -1);
        check("bcast0.len0", 64'(rx_len), 0);

        build(7, local_mac, 16'h0800, 8'h45, 8'h11, local_ip, local_port, 16'd1032, 1024, -1, 1'b0);
        run("trunc100", 8 + 42 + 100, -1);
        check("trunc100.nbeats", 64'(mon_q.size()), 100);

        build(7, local_mac, 16'h0800, 8'h45, 8'h11, local_ip, local_port, 16'd28, 20, -1, 1'b1);
        send(frm.size(), -1, 8 + 42 + 4);
        exp_len = 0; exp_sip = 0; exp_sport = 0;
        check("midrst.beats", 64'(mon_q.size()), 4);
        check("midrst.pulses", 64'(ok_cnt + err_cnt), 0);
        check("midrst.outs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_ok, frame_err}, 0);
        check("midrst.regs", {rx_src_ip, rx_src_port, rx_len}, 0);

        build(5, local_mac, 16'h0800, 8'h45, 8'h11, local_ip, local_port, 16'd40, 32, -1, 1'b0);
        run("after_rst", frm.size(), -1);

        build(5, local_mac, 16'h0800, 8'h45, 8'h11, local_ip, local_port, 16'd38, 30, -1, 1'b0);
        run("rx_er", frm.size(), 6 + 42 + 10);
        check("rx_er.nbeats", 64'(mon_q.size()), 10);

        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 10);
            npre  = $urandom_range(1, 7);
            dmac  = local_mac; etype = 16'h0800; ip0 = 8'h45; proto = 8'h11;
            dip   = local_ip;  dport = local_port;
            npay  = $urandom_range(0, 40);
            ulen  = npay + 8;
            flip  = -1;
            case (kind)
                1: dmac = local_mac ^ (48'h1 << $urandom_range(0, 47));
                2: dmac = 48'hFFFF_FFFF_FFFF;
                3: etype = ($urandom_range(0, 1) != 0) ? 16'h0806 : 16'h86DD;
                4: ip0 = 8'h46;
                5: proto = 8'h06;
                6: dip = local_ip ^ (32'h1 << $urandom_range(0, 31));
                7: dport = local_port ^ (16'h1 << $urandom_range(0, 15));
                8: begin ulen = $urandom_range(0, 7); npay = 4; end
                9: flip = $urandom_range(0, 31);
                10: npre = 0;
                default: ;
            endcase
            build(npre, dmac, etype, ip0, proto, dip, dport, 16'(ulen), npay, flip, 1'b0);
            n = frm.size();
            e = -1;
            if ($urandom_range(0, 4) == 0) n = $urandom_range(1, frm.size());
            if (n > 1 && $urandom_range(0, 5) == 0) e = $urandom_range(1, n - 1);
            run($sformatf("rnd%0d", t), n, e);
        end

        check("never_both", 64'(both_cnt), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
